flash_sample_fetcher: RTL and testbench

- Upstream stage of the audio playback path. Fetches 32-bit words from the on-board flash over an Avalon-MM pipelined read interface and splits each word into two 16-bit audio samples.
- Presents one sample at a time on a valid/ack handshake. The downstream sample-passing stage acks each sample on its audio-rate tick.
- Supports forward/backward playback, pause, restart and address wrap over the song region.

---
 rtl/flash_sample_fetcher.sv | 160 ++++++++++++++++
 tb/tb_flash_sample_fetcher.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_fetcher.sv
// Fetches 32-bit words from flash (Avalon-MM pipelined read, one outstanding) and hands them out
// as two 16-bit samples on a valid/ack handshake. End-of-song parking unless FSF_LOOP_EN is defined.
module flash_sample_fetcher #(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic              clock50,
  input  logic              rstn,
  input  logic              sample_ack,
  input  logic              direction,
  input  logic              pause,
  input  logic              restart,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              end_of_song
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_HAVE_WORD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              word_dir_q, word_dir_d;
  logic              half_q, half_d;
  logic              rst_pend_q, rst_pend_d;
  logic              eos_q, eos_d;

  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] step_addr;
  logic              step_eos;

  assign start_addr = direction ? MAX_ADDR : '0;

  // Next word address; at the region ends either wrap or flag end of song.
  always_comb begin
    step_addr = addr_q;
    step_eos  = 1'b0;
    if (!direction) begin
      if (addr_q == MAX_ADDR) begin
`ifdef FSF_LOOP_EN
        step_addr = '0;
`else
        step_eos  = 1'b1;
`endif
      end else begin
        step_addr = addr_q + 1'b1;
      end
    end else begin
      if (addr_q == '0) begin
`ifdef FSF_LOOP_EN
        step_addr = MAX_ADDR;
`else
        step_eos  = 1'b1;
`endif
      end else begin
        step_addr = addr_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    word_dir_d = word_dir_q;
    half_d     = half_q;
    rst_pend_d = rst_pend_q;
    eos_d      = eos_q;
    case (state_q)
      S_IDLE: begin
        if (restart) begin
          addr_d = start_addr;
          half_d = 1'b0;
          eos_d  = 1'b0;
        end else if (!pause && !eos_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (restart) rst_pend_d = 1'b1;
        if (!flash_mem_waitrequest) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (restart) rst_pend_d = 1'b1;
        if (flash_mem_readdatavalid) begin
          // A restart seen while the read was in flight discards this word.
          if (rst_pend_q || restart) begin
            rst_pend_d = 1'b0;
            addr_d     = start_addr;
            half_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            word_d     = flash_mem_readdata;
            word_dir_d = direction;
            half_d     = 1'b0;
            state_d    = S_HAVE_WORD;
          end
        end
      end
      S_HAVE_WORD: begin
        if (restart) begin
          addr_d  = start_addr;
          half_d  = 1'b0;
          eos_d   = 1'b0;
          state_d = S_IDLE;
        end else if (sample_ack && !pause) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d  = 1'b0;
            addr_d  = step_addr;
            eos_d   = step_eos;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock50 or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      word_dir_q <= 1'b0;
      half_q     <= 1'b0;
      rst_pend_q <= 1'b0;
      eos_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      word_dir_q <= word_dir_d;
      half_q     <= half_d;
      rst_pend_q <= rst_pend_d;
      eos_q      <= eos_d;
    end
  end

  assign flash_mem_read       = (state_q == S_REQ);
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = 4'hF;
  // Backward words present the upper half first.
  assign sample_out           = (half_q ^ word_dir_q) ? word_q[31:16] : word_q[15:0];
  assign sample_valid         = (state_q == S_HAVE_WORD) && !pause;
  assign end_of_song          = eos_q;

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Bench for flash_sample_fetcher: Avalon flash responder with per-address stall/latency,
// sample scoreboard, table of playback vectors and hand-written restart/pause/reset sequences.
module tb_flash_sample_fetcher;

  localparam logic [22:0] MAXA = 23'h7FFFF;

  logic        clock50, rstn, sample_ack, direction, pause, restart;
  logic        flash_mem_read, flash_mem_waitrequest, flash_mem_readdatavalid;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_readdata;
  logic [15:0] sample_out;
  logic        sample_valid, end_of_song;

  flash_sample_fetcher dut (
    .clock50                 (clock50),
    .rstn                    (rstn),
    .sample_ack              (sample_ack),
    .direction               (direction),
    .pause                   (pause),
    .restart                 (restart),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .sample_out              (sample_out),
    .sample_valid            (sample_valid),
    .end_of_song             (end_of_song)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [int];
  logic [15:0] sb [$];
  logic [22:0] got_addr [$];
  int          got_hold [$];
  int          pend_lat = 0;
  int          hold_cnt = 0;
  logic [31:0] pend_data = '0;
  int          sv_cycles = 0;

  typedef struct {
    bit          dir;
    bit          rst_before;
    bit          pa;
    logic [22:0] addr;
    logic [31:0] data;
    logic [15:0] s0;
    logic [15:0] s1;
  } vec_t;
  vec_t vt [6];

  initial begin
    clock50 = 1'b0;
    forever #10 clock50 = ~clock50;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge clock50) if (sample_valid) sv_cycles <= sv_cycles + 1;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {a[7:0], 8'h3C, ~a[7:0], 8'hA5};
  endfunction

  function automatic int stall_of(input logic [22:0] a);
    return (int'(a) + 2) % 3;
  endfunction

  function automatic int lat_of(input logic [22:0] a);
    return (int'(a) % 4) + 3;
  endfunction

  // Flash responder: stalls each request stall_of() cycles, returns data lat_of() cycles after accept.
  initial begin
    flash_mem_waitrequest   = 1'b1;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    forever begin
      @(negedge clock50);
      flash_mem_readdatavalid = 1'b0;
      if (pend_lat > 0) begin
        pend_lat--;
        if (pend_lat == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata      = pend_data;
        end
      end
      if (flash_mem_read) begin
        hold_cnt++;
        if (hold_cnt > stall_of(flash_mem_address)) begin
          flash_mem_waitrequest = 1'b0;
          got_addr.push_back(flash_mem_address);
          got_hold.push_back(hold_cnt);
          pend_data = mem_word(flash_mem_address);
          pend_lat  = lat_of(flash_mem_address);
          hold_cnt  = 0;
        end else begin
          flash_mem_waitrequest = 1'b1;
        end
      end else begin
        flash_mem_waitrequest = 1'b1;
        hold_cnt = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_read(input logic [22:0] a);
    int n = 0;
    while (got_addr.size() == 0 && n < 300) begin
      @(negedge clock50);
      n++;
    end
    if (got_addr.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: no read seen, expected address %h", a);
    end else begin
      check("read_addr", {9'd0, got_addr.pop_front()}, {9'd0, a});
      check("read_hold", got_hold.pop_front(), stall_of(a) + 1);
    end
  endtask

  task automatic consume(input bit pa);
    int n = 0;
    logic [15:0] exp;
    @(negedge clock50);
    while (!sample_valid && n < 300) begin
      @(negedge clock50);
      n++;
    end
    if (!sample_valid) begin
      checks++;
      errors++;
      $display("FAIL sample_timeout: sample_valid never rose");
    end else begin
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
      check("sample", {16'd0, sample_out}, {16'd0, exp});
      sample_ack = 1'b1;
      @(negedge clock50);
      sample_ack = 1'b0;
      pause      = pa;
    end
  endtask

  task automatic pulse_restart();
    @(negedge clock50);
    restart = 1'b1;
    @(negedge clock50);
    restart = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_read",  {31'd0, flash_mem_read}, 32'd0);
    check("rst_addr",  {9'd0, flash_mem_address}, 32'd0);
    check("rst_be",    {28'd0, flash_mem_byteenable}, 32'hF);
    check("rst_sout",  {16'd0, sample_out}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_eos",   {31'd0, end_of_song}, 32'd0);
  endtask

  initial begin
    int n;
    int sv0;
    vt[0] = '{1'b0, 1'b0, 1'b0, 23'd1,    32'h0001_8000, 16'h8000, 16'h0001};
    vt[1] = '{1'b0, 1'b0, 1'b0, 23'd2,    32'hFFFF_0000, 16'h0000, 16'hFFFF};
    vt[2] = '{1'b0, 1'b0, 1'b1, 23'd3,    32'h1234_5678, 16'h5678, 16'h1234};
    vt[3] = '{1'b1, 1'b1, 1'b0, MAXA,     32'h2222_1111, 16'h2222, 16'h1111};
    vt[4] = '{1'b1, 1'b0, 1'b0, MAXA - 1, 32'hCAFE_BEEF, 16'hCAFE, 16'hBEEF};
    vt[5] = '{1'b1, 1'b0, 1'b1, MAXA - 2, 32'h0F0F_F0F0, 16'h0F0F, 16'hF0F0};
    for (int i = 0; i < 6; i++) mem[int'(vt[i].addr)] = vt[i].data;
    mem[0] = 32'hBBBB_AAAA;

    sample_ack = 1'b0; direction = 1'b0; pause = 1'b0; restart = 1'b0;
    rstn = 1'b1;
    #3 rstn = 1'b0;
    #4 check_reset_vals();
    repeat (3) @(negedge clock50);
    rstn = 1'b1;

    // Forward word at address 0 with a 2-cycle stall and 3-cycle latency.
    expect_read(23'd0);
    sb.push_back(16'hAAAA); sb.push_back(16'hBBBB);
    consume(1'b0);
    consume(1'b0);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].rst_before) begin
        direction = vt[i].dir;
        pulse_restart();
        pause = 1'b0;
      end
      expect_read(vt[i].addr);
      sb.push_back(vt[i].s0); sb.push_back(vt[i].s1);
      consume(1'b0);
      consume(vt[i].pa);
    end

    // Forward playback of the last word in the region.
    direction = 1'b1;
    pulse_restart();
    direction = 1'b0;
    pause = 1'b0;
    expect_read(MAXA);
    sb.push_back(16'h1111); sb.push_back(16'h2222);
    consume(1'b0);
    consume(1'b0);
`ifdef FSF_LOOP_EN
    expect_read(23'd0);
    check("loop_eos", {31'd0, end_of_song}, 32'd0);
`else
    repeat (30) @(negedge clock50);
    check("eos_no_read", got_addr.size(), 0);
    check("eos_set", {31'd0, end_of_song}, 32'd1);
    pulse_restart();
    check("eos_clr", {31'd0, end_of_song}, 32'd0);
    expect_read(23'd0);
`endif

    // Walk forward to address 5, then restart while its read is in flight.
    for (int a = 0; a < 5; a++) begin
      sb.push_back(mem_word(23'(a)) >> 0 & 32'hFFFF);
      sb.push_back(mem_word(23'(a)) >> 16);
      consume(1'b0);
      consume(1'b0);
      expect_read(23'(a + 1));
    end
    mem[0] = 32'h5678_1234;
    @(posedge clock50);
    pulse_restart();
    sv0 = sv_cycles;
    expect_read(23'd0);
    check("discard_no_valid", sv_cycles, sv0);
    check("discard_sb_empty", sb.size(), 0);

    // Pause while 16'h1234 is presented; acks must be ignored.
    sb.push_back(16'h1234); sb.push_back(16'h5678);
    n = 0;
    @(negedge clock50);
    while (!sample_valid && n < 300) begin
      @(negedge clock50);
      n++;
    end
    check("pause_pre_valid", {31'd0, sample_valid}, 32'd1);
    pause = 1'b1;
    @(negedge clock50);
    check("pause_valid_low", {31'd0, sample_valid}, 32'd0);
    repeat (3) begin
      sample_ack = 1'b1;
      @(negedge clock50);
      sample_ack = 1'b0;
      @(negedge clock50);
    end
    check("pause_valid_hold", {31'd0, sample_valid}, 32'd0);
    check("pause_sout_hold", {16'd0, sample_out}, 32'h1234);
    check("pause_addr_hold", {9'd0, flash_mem_address}, 32'd0);
    check("pause_no_read", got_addr.size(), 0);
    pause = 1'b0;
    consume(1'b0);
    consume(1'b0);

    // Asynchronous reset in the middle of the next request.
    n = 0;
    do begin
      @(posedge clock50);
      #2;
      n++;
    end while (!flash_mem_read && n < 50);
    check("mid_req_read_hi", {31'd0, flash_mem_read}, 32'd1);
    rstn = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(negedge clock50);
    check("mid_req_no_accept", got_addr.size(), 0);
    rstn = 1'b1;
    expect_read(23'd0);
    sb.push_back(16'h1234); sb.push_back(16'h5678);
    consume(1'b0);
    consume(1'b0);
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
